// File: rtl/mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM states,
// Booth partial-product selects and the iteration count.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_P1   = 3'd1,
    SEL_P2   = 3'd2,
    SEL_M1   = 3'd3,
    SEL_M2   = 3'd4
  } booth_sel_t;

  // Two extension bits keep the unsigned path identical to the signed one.
  function automatic int iters(input int width);
    return width / 2 + 1;
  endfunction

  function automatic booth_sel_t booth_recode(input logic [2:0] grp);
    booth_sel_t sel;
    case (grp)
      3'b001, 3'b010: sel = SEL_P1;
      3'b011:         sel = SEL_P2;
      3'b100:         sel = SEL_M2;
      3'b101, 3'b110: sel = SEL_M1;
      default:        sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector: maps a 3-bit multiplier window
// onto 0, +/-M or +/-2M at accumulator width.
module booth_r4_sel
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              [2:0]       i_grp,
  input  logic signed       [WIDTH+1:0] i_m_ext,
  output logic signed       [WIDTH+3:0] o_addend
);

  logic signed [WIDTH+3:0] w_m1;
  logic signed [WIDTH+3:0] w_m2;
  booth_sel_t              w_sel;

  assign w_m1  = {{2{i_m_ext[WIDTH+1]}}, i_m_ext};
  assign w_m2  = {i_m_ext[WIDTH+1], i_m_ext, 1'b0};
  assign w_sel = booth_recode(i_grp);

  always_comb begin
    o_addend = '0;
    case (w_sel)
      SEL_P1:  o_addend = w_m1;
      SEL_P2:  o_addend = w_m2;
      SEL_M1:  o_addend = -w_m1;
      SEL_M2:  o_addend = -w_m2;
      default: o_addend = '0;
    endcase
  end

endmodule

// File: rtl/mult_booth_r4.sv
// Sequential radix-4 Booth multiplier with start/busy/result_rdy handshake;
// retires two multiplier bits per cycle and holds the last product on out.
module mult_booth_r4
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 result_rdy,
  output logic [2*WIDTH-1:0]   out
);

  localparam int N     = iters(WIDTH);
  localparam int CNT_W = $clog2(N + 1);
  localparam int AW    = WIDTH + 4;
  localparam int PW    = WIDTH + 3;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [AW-1:0]     r_a;
  logic [PW-1:0]            r_p;
  logic signed [WIDTH+1:0]  r_m;

  logic signed [AW-1:0]     w_addend;
  logic signed [AW-1:0]     w_sum;
  logic signed [AW-1:0]     w_a_next;
  logic [PW-1:0]            w_p_next;
  logic signed [WIDTH+1:0]  w_m_ext;
  logic [WIDTH+1:0]         w_q_ext;
  logic                     w_last;

  booth_r4_sel #(.WIDTH(WIDTH)) u_sel (
    .i_grp    (r_p[2:0]),
    .i_m_ext  (r_m),
    .o_addend (w_addend)
  );

  assign w_m_ext = {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
  assign w_q_ext = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};

  // Add the selected term, then shift {A,P} right by two as one signed value.
  assign w_sum    = r_a + w_addend;
  assign w_a_next = w_sum >>> 2;
  assign w_p_next = {w_sum[1:0], r_p[PW-1:2]};
  assign w_last   = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      result_rdy <= 1'b0;
      out        <= '0;
      r_a        <= '0;
      r_p        <= '0;
      r_m        <= '0;
      r_cnt      <= '0;
    end else begin
      busy       <= 1'b0;
      result_rdy <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUN;
            busy    <= 1'b1;
            r_a     <= '0;
            r_p     <= {w_q_ext, 1'b0};
            r_m     <= w_m_ext;
            r_cnt   <= CNT_W'(N);
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a   <= w_a_next;
          r_p   <= w_p_next;
          r_cnt <= r_cnt - 1'b1;
          // Low 2W product bits: top of A above the bits shifted into P.
          if (w_last) begin
            r_state    <= DONE;
            result_rdy <= 1'b1;
            out        <= {w_a_next[WIDTH-3:0], w_p_next[PW-1:1]};
          end else begin
            busy <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
